// File: rtl/toggle_req_gen.sv
// toggle_req_gen: T-pulse generator for a T flip-flop; optional feedback checker under TOGGLE_CHECK_EN
module toggle_req_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             burst_mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] burst,
  output logic             T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_cnt
`ifdef TOGGLE_CHECK_EN
  ,
  input  logic             q_fb,
  output logic             chk_err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] p_r, p_n, burst_r, burst_n, cnt, cnt_n, pcnt_n, pcnt_inc;
  logic mode_r, mode_n, t_n, busy_n, done_n;
  assign pcnt_inc = pulse_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p_r       <= '0;
      burst_r   <= '0;
      mode_r    <= 1'b0;
      cnt       <= '0;
      pulse_cnt <= '0;
      T         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      p_r       <= p_n;
      burst_r   <= burst_n;
      mode_r    <= mode_n;
      cnt       <= cnt_n;
      pulse_cnt <= pcnt_n;
      T         <= t_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    p_n     = p_r;
    burst_n = burst_r;
    mode_n  = mode_r;
    cnt_n   = cnt;
    pcnt_n  = pulse_cnt;
    t_n     = 1'b0;
    if (state == IDLE) begin
      if (start && !stop) begin
        state_n = RUN;
        p_n     = (period == '0) ? WIDTH'(1) : period;
        burst_n = burst;
        mode_n  = burst_mode;
        cnt_n   = p_n - 1'b1;
        pcnt_n  = '0;
      end
    end else if (stop || state == DONE) begin
      state_n = IDLE;
    end else if (mode_r && burst_r == '0) begin
      state_n = DONE;
    end else if (!hold) begin
      if (cnt == '0) begin
        t_n    = 1'b1;
        cnt_n  = p_r - 1'b1;
        pcnt_n = pcnt_inc;
        state_n = (mode_r && pcnt_inc == burst_r) ? DONE : RUN;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end
    // busy stays up through the final burst pulse and drops as done rises
    busy_n = (state_n == RUN) || (state == RUN && state_n == DONE);
    done_n = (state == DONE) && !stop;
  end
`ifdef TOGGLE_CHECK_EN
  logic t_d, q_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_d     <= 1'b0;
      q_d     <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      t_d     <= T;
      q_d     <= q_fb;
      chk_err <= chk_err | (t_d ^ q_fb ^ q_d);
    end
  end
`endif
endmodule
